// File: rtl/store_align_unit.sv
// -----------------------------------------------------------------------------
// store_align_unit
//
// Takes one RISC-V store (SB/SH/SW) per request handshake and turns it into
// one or two write beats on a 32-bit word-addressed data memory port. Store
// data is moved onto the byte lanes selected by addr[1:0], and matching byte
// enables are generated. A store that crosses a word boundary is split into
// two beats: the lower word first, then the next word (address + 4, wrapping).
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   synchronous, active-high reset
//   req_valid   in   store request present
//   req_ready   out  request can be accepted (IDLE and not in reset)
//   funct3      in   000 SB, 001 SH, 010 SW; anything else is illegal
//   addr        in   byte address of the store
//   wdata       in   store data (low 8/16/32 bits used)
//   dmem_valid  out  write beat present (BEAT0 or BEAT1)
//   dmem_ready  in   memory accepts the beat this cycle
//   dmem_addr   out  word-aligned beat address
//   dmem_wdata  out  lane-aligned beat data, unused lanes zero
//   dmem_we     out  byte enables, bit i -> bits [8i+7:8i]
//   busy        out  high while a beat is outstanding
//   done        out  one-cycle pulse after the final beat handshake
//   err         out  one-cycle pulse after an illegal funct3 is accepted
// -----------------------------------------------------------------------------
module store_align_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        dmem_valid,
  input  logic        dmem_ready,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_we,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BEAT0 = 2'd1;
  localparam logic [1:0] S_BEAT1 = 2'd2;

  // Store-type decode helpers.
  function automatic logic f_legal(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
  endfunction

  function automatic logic [3:0] f_byte_mask(input logic [2:0] f3);
    case (f3)
      3'b000:  return 4'b0001;
      3'b001:  return 4'b0011;
      3'b010:  return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] f_size_mask(input logic [2:0] f3);
    case (f3)
      3'b000:  return 32'h0000_00FF;
      3'b001:  return 32'h0000_FFFF;
      3'b010:  return 32'hFFFF_FFFF;
      default: return 32'h0000_0000;
    endcase
  endfunction

  logic [1:0]  r_state;
  logic [31:0] r_dmem_addr;
  logic [31:0] r_dmem_wdata;
  logic [3:0]  r_dmem_we;
  logic [31:0] r_hi_wdata;   // upper half of the shifted data, used by BEAT1
  logic [3:0]  r_hi_we;      // upper half of the shifted mask; nonzero => split
  logic        r_done;
  logic        r_err;

  logic [1:0]  w_offset;
  logic [7:0]  w_mask8;
  logic [63:0] w_data64;

  // Shifting into an 8-bit mask / 64-bit data word lets the spill-over into
  // the next word fall out naturally in the upper halves.
  assign w_offset = addr[1:0];
  assign w_mask8  = {4'b0000, f_byte_mask(funct3)} << w_offset;
  assign w_data64 = {32'h0000_0000, wdata & f_size_mask(funct3)} << {w_offset, 3'b000};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_dmem_addr  <= 32'h0000_0000;
      r_dmem_wdata <= 32'h0000_0000;
      r_dmem_we    <= 4'b0000;
      r_hi_wdata   <= 32'h0000_0000;
      r_hi_we      <= 4'b0000;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // req_ready is simply "IDLE and not reset", so req_valid alone
          // means acceptance here.
          if (req_valid) begin
            if (f_legal(funct3)) begin
              r_state      <= S_BEAT0;
              r_dmem_addr  <= {addr[31:2], 2'b00};
              r_dmem_we    <= w_mask8[3:0];
              r_dmem_wdata <= w_data64[31:0];
              r_hi_we      <= w_mask8[7:4];
              r_hi_wdata   <= w_data64[63:32];
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_BEAT0: begin
          if (dmem_ready) begin
            if (r_hi_we != 4'b0000) begin
              r_state      <= S_BEAT1;
              r_dmem_addr  <= r_dmem_addr + 32'd4;  // wraps modulo 2^32
              r_dmem_we    <= r_hi_we;
              r_dmem_wdata <= r_hi_wdata;
            end else begin
              r_state      <= S_IDLE;
              r_dmem_we    <= 4'b0000;
              r_dmem_wdata <= 32'h0000_0000;
              r_done       <= 1'b1;
            end
          end
        end
        S_BEAT1: begin
          if (dmem_ready) begin
            r_state      <= S_IDLE;
            r_dmem_we    <= 4'b0000;
            r_dmem_wdata <= 32'h0000_0000;
            r_done       <= 1'b1;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_dmem_we    <= 4'b0000;
          r_dmem_wdata <= 32'h0000_0000;
        end
      endcase
    end
  end

  assign req_ready  = (r_state == S_IDLE) && !reset;
  assign dmem_valid = (r_state == S_BEAT0) || (r_state == S_BEAT1);
  assign busy       = dmem_valid;
  assign dmem_addr  = r_dmem_addr;
  assign dmem_wdata = r_dmem_wdata;
  assign dmem_we    = r_dmem_we;
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: doc/store_align_unit.md
# store_align_unit

Store-side counterpart of the load mask/shift path. Accepts one RISC-V store (SB/SH/SW) per handshake, places the store data on the correct byte lanes of a 32-bit word-addressed data memory, and generates the 4-bit byte-write enables. Misaligned stores that straddle a word boundary are split into two sequential memory beats. Sits between the execute/MEM stage and the data-memory write port.

## Interface
- No parameters. Data width fixed at 32, byte-enable width fixed at 4.
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  store request present
- req_ready  out  1  unit can accept a request; `(state == IDLE) && !reset`
- funct3  in  3  store type: 000 SB, 001 SH, 010 SW; any other value is illegal
- addr  in  32  byte address of the store
- wdata  in  32  rs2 value; the low 8, 16 or 32 bits are used
- dmem_valid  out  1  memory write beat present
- dmem_ready  in  1  memory accepts the beat this cycle
- dmem_addr  out  32  word-aligned address, `[1:0] = 00`
- dmem_wdata  out  32  lane-aligned write data; unused lanes are 0
- dmem_we  out  4  byte enables; bit i is byte lane i (`[8i+7:8i]`)
- busy  out  1  high in BEAT0 and BEAT1
- done  out  1  one-cycle pulse after the final beat handshake
- err  out  1  one-cycle pulse after an illegal funct3 is accepted

## Operation
- Handshake: a request is accepted when `req_valid && req_ready`. funct3, addr and wdata are registered at acceptance. Inputs are don't-care at all other times.
- Decode at acceptance:
  - Offset: `o = addr[1:0]`.
  - Mask: 0001 for SB, 0011 for SH, 1111 for SW.
  - Form the 8-bit value `M = mask << o` and the 64-bit value `D = {32'b0, wdata_masked} << (8*o)`, where `wdata_masked` zeroes the bits above the store size.
- Beat 0: `dmem_addr = {addr[31:2], 2'b00}`, `dmem_we = M[3:0]`, `dmem_wdata = D[31:0]`.
- Split: a second beat is needed iff `M[7:4] != 0`. This occurs for SH at o=3 and for SW at o=1, 2 or 3.
- Beat 1: `dmem_addr = beat0 addr + 4`, wrapping modulo 2^32 (0xFFFFFFFC becomes 0x00000000). `dmem_we = M[7:4]`, `dmem_wdata = D[63:32]`.
- States:
  - IDLE → BEAT0 on acceptance with legal funct3.
  - IDLE stays in IDLE on acceptance with illegal funct3. err is set for the next cycle. No beat is issued and done is not asserted.
  - BEAT0 holds until dmem_ready. On the handshake: go to BEAT1 if split, otherwise go to IDLE and set done.
  - BEAT1 holds until dmem_ready. On the handshake: go to IDLE and set done.
- dmem_valid is 1 exactly in BEAT0 and BEAT1. dmem_addr, dmem_we and dmem_wdata are registered and held stable while dmem_valid=1 and dmem_ready=0.
- In IDLE, dmem_we = 0 and dmem_wdata = 0. dmem_addr holds its last value.
- dmem_ready is ignored in IDLE.

## Timing
- Reset values: state=IDLE, dmem_valid=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, busy=0, done=0, err=0.
- req_ready is 0 during every cycle that reset is high, and 1 in the first cycle after reset deasserts.
- Reset mid-operation (BEAT0 or BEAT1): the next cycle is IDLE with all outputs at their reset values. The pending beat(s) are dropped and no done is produced.
- Latency, with acceptance at cycle N:
  - BEAT0 is presented at N+1.
  - With dmem_ready held at 1: an unsplit store has done=1 at N+2; a split store presents BEAT1 at N+2 and has done=1 at N+3.
  - Each dmem_ready=0 cycle adds one cycle.
- done and err are high for exactly one cycle, in IDLE. req_ready is 1 in that same cycle, so back-to-back stores are accepted every 2 cycles (unsplit) or every 3 cycles (split).
- done and err are never high in the same cycle.

## Test plan
- SB, addr=0x1003, wdata=0xAABBCCDD, dmem_ready=1 → single beat: dmem_addr=0x1000, we=1000, wdata=0xDD000000; done at N+2.
- SH, addr=0x2002, wdata=0x12345678 → single beat: addr=0x2000, we=1100, wdata=0x56780000. Then SH at addr=0x2003 → beat0: addr=0x2000, we=1000, wdata=0x78000000; beat1: addr=0x2004, we=0001, wdata=0x00000056; done at N+3.
- SW, addr=0xFFFFFFFD, wdata=0x11223344 → beat0: addr=0xFFFFFFFC, we=1110, wdata=0x22334400; beat1: addr=0x00000000, we=0001, wdata=0x00000011.
- SW, addr=0x4000, with dmem_ready held 0 for 3 cycles → dmem_valid, dmem_addr=0x4000, we=1111 and wdata=wdata stable for all 4 cycles; done one cycle after the ready cycle; req_ready=0 throughout.
- funct3=011, req_valid=1 → err=1 next cycle, dmem_valid never asserted, done=0; a legal SB in the following cycle is accepted normally.
- Split SW at addr=0x5001, reset asserted in BEAT1 → next cycle: dmem_valid=0, we=0, busy=0, done=0; req_ready=1 the cycle after reset deasserts.
